// File: rtl/pipe_reg_file.sv
// Pipelined register file: owns the destination delay line, retires writes WB_DELAY
// cycles after issue, and provides write-to-read bypass, busy flags and flush.

module pipe_reg_file_stage #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              hit_a,
  output logic              hit_b
);
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    vld_d  = vld_i & ~flush;
    addr_d = addr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign hit_a  = vld_q & (addr_q == rd_addr_a);
  assign hit_b  = vld_q & (addr_q == rd_addr_b);
endmodule

module pipe_reg_file #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int WB_DELAY  = 3,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              dest_valid,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              wb_err
);
  // Index 0 is the issue slot feeding stage 0; index WB_DELAY is the tail.
  logic [WB_DELAY:0]              vld_pipe;
  logic [WB_DELAY:0][ADDR_W-1:0]  addr_pipe;
  logic [WB_DELAY-1:0]            hit_a, hit_b;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]               rd_data_b_q, rd_data_b_d;
  logic                            wb_err_q, wb_err_d;

  logic              tail_vld;
  logic [ADDR_W-1:0] tail_addr;
  logic              wb_fire;

  assign vld_pipe[0]  = issue_valid & dest_valid & ~flush;
  assign addr_pipe[0] = dest_addr;

  for (genvar s = 0; s < WB_DELAY; s++) begin : g_stage
    pipe_reg_file_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (flush),
      .vld_i     (vld_pipe[s]),
      .addr_i    (addr_pipe[s]),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .vld_o     (vld_pipe[s+1]),
      .addr_o    (addr_pipe[s+1]),
      .hit_a     (hit_a[s]),
      .hit_b     (hit_b[s])
    );
  end

  assign tail_vld  = vld_pipe[WB_DELAY];
  assign tail_addr = addr_pipe[WB_DELAY];
  assign wb_fire   = wb_en & tail_vld;

  // A retiring tail is covered by the read bypass, so it only counts as busy
  // when no write-back strobe is present.
  always_comb begin
    busy_a = hit_a[WB_DELAY-1] & ~wb_en;
    busy_b = hit_b[WB_DELAY-1] & ~wb_en;
    for (int i = 0; i < WB_DELAY - 1; i++) begin
      busy_a = busy_a | hit_a[i];
      busy_b = busy_b | hit_b[i];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_fire) regs_d[tail_addr] = wb_data;
    rd_data_a_d = (wb_fire && tail_addr == rd_addr_a) ? wb_data : regs_q[rd_addr_a];
    rd_data_b_d = (wb_fire && tail_addr == rd_addr_b) ? wb_data : regs_q[rd_addr_b];
    wb_err_d    = wb_en & ~tail_vld;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign wb_err    = wb_err_q;
endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: default instance (16b/8 regs/delay 3) and a
// 32b/16 regs/delay 1 instance, checked against hand-computed values.

module tb_pipe_reg_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        iv, dv, fl, we;
  logic [2:0]  ra, rb, da;
  logic [15:0] wd, rda, rdb;
  logic        bsa, bsb, err;

  // swept instance
  logic        iv1, dv1, fl1, we1;
  logic [3:0]  ra1, rb1, da1;
  logic [31:0] wd1, rda1, rdb1;
  logic        bsa1, bsb1, err1;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_reg_file u0 (
    .clk(clk), .reset(reset), .issue_valid(iv), .rd_addr_a(ra), .rd_addr_b(rb),
    .dest_valid(dv), .dest_addr(da), .flush(fl), .wb_en(we), .wb_data(wd),
    .rd_data_a(rda), .rd_data_b(rdb), .busy_a(bsa), .busy_b(bsb), .wb_err(err)
  );

  pipe_reg_file #(.DATA_W(32), .NUM_REGS(16), .WB_DELAY(1), .INIT_MODE(1)) u1 (
    .clk(clk), .reset(reset), .issue_valid(iv1), .rd_addr_a(ra1), .rd_addr_b(rb1),
    .dest_valid(dv1), .dest_addr(da1), .flush(fl1), .wb_en(we1), .wb_data(wd1),
    .rd_data_a(rda1), .rd_data_b(rdb1), .busy_a(bsa1), .busy_b(bsb1), .wb_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge; inputs set afterwards
  // belong to the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    iv = 0; dv = 0; fl = 0; we = 0; ra = 0; rb = 0; da = 0; wd = '0;
    iv1 = 0; dv1 = 0; fl1 = 0; we1 = 0; ra1 = 0; rb1 = 0; da1 = 0; wd1 = '0;

    // reset state
    #2;
    chk("rst_rda", 32'(rda), 32'h0);
    chk("rst_rdb", 32'(rdb), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    #10 reset = 1'b1;

    // INIT_MODE=1 contents
    ra = 3'd5; rb = 3'd7; ra1 = 4'd9;
    step();
    chk("init_rda", 32'(rda), 32'd5);
    chk("init_rdb", 32'(rdb), 32'd7);
    chk("init_busy_a", 32'(bsa), 32'd0);
    chk("init_busy_b", 32'(bsb), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("u1_init_rda", rda1, 32'd9);

    // issue dest=3, retire 0xBEEF three cycles later via bypass
    iv = 1; dv = 1; da = 3'd3; ra = 3'd3; rb = 3'd0;
    #1 chk("own_issue_busy", 32'(bsa), 32'd0);
    step();                               // cycle 1
    iv = 0; dv = 0;
    #1 chk("beef_busy_c1", 32'(bsa), 32'd1);
    step();                               // cycle 2
    #1 chk("beef_busy_c2", 32'(bsa), 32'd1);
    step();                               // cycle 3
    we = 1; wd = 16'hBEEF;
    #1 chk("beef_busy_c3", 32'(bsa), 32'd0);
    step();                               // cycle 4
    we = 0; rb = 3'd3;
    chk("beef_bypass", 32'(rda), 32'hBEEF);
    chk("beef_no_err", 32'(err), 32'd0);
    step();
    chk("beef_reg_a", 32'(rda), 32'hBEEF);
    chk("beef_reg_b", 32'(rdb), 32'hBEEF);

    // flush squashes dest=2; late wb_en becomes an error
    iv = 1; dv = 1; da = 3'd2; ra = 3'd2;
    step();                               // cycle 1
    iv = 0; dv = 0; fl = 1;
    #1 chk("fl_busy_c1", 32'(bsa), 32'd1);
    step();                               // cycle 2
    fl = 0;
    #1 chk("fl_busy_c2", 32'(bsa), 32'd0);
    step();                               // cycle 3
    we = 1; wd = 16'h5555;
    step();                               // cycle 4
    we = 0;
    chk("fl_err_c4", 32'(err), 32'd1);
    chk("fl_no_write", 32'(rda), 32'd2);
    step();
    chk("fl_err_c5", 32'(err), 32'd0);
    chk("fl_reg2", 32'(rda), 32'd2);

    // duplicate dest=4, last write wins
    iv = 1; dv = 1; da = 3'd4; ra = 3'd4;
    step();                               // cycle 1
    #1 chk("dup_busy_c1", 32'(bsa), 32'd1);
    step();                               // cycle 2
    iv = 0; dv = 0;
    #1 chk("dup_busy_c2", 32'(bsa), 32'd1);
    step();                               // cycle 3
    we = 1; wd = 16'h0011;
    #1 chk("dup_busy_c3", 32'(bsa), 32'd1);
    step();                               // cycle 4
    wd = 16'h0022;
    #1 chk("dup_busy_c4", 32'(bsa), 32'd0);
    chk("dup_first", 32'(rda), 32'h0011);
    step();                               // cycle 5
    we = 0;
    chk("dup_second", 32'(rda), 32'h0022);
    step();
    chk("dup_reg4", 32'(rda), 32'h0022);

    // tail valid with wb_en=0 is dropped silently
    iv = 1; dv = 1; da = 3'd6; ra = 3'd6;
    step();
    iv = 0; dv = 0;
    repeat (3) step();
    #1 chk("drop_busy", 32'(bsa), 32'd0);
    step();
    chk("drop_reg6", 32'(rda), 32'd6);
    chk("drop_no_err", 32'(err), 32'd0);

    // async reset with three pending entries
    ra = 3'd1; rb = 3'd7;
    iv = 1; dv = 1; da = 3'd1;
    step();
    da = 3'd2;
    step();
    da = 3'd3;
    step();
    iv = 0; dv = 0;
    #1 chk("pre_rst_busy", 32'(bsa), 32'd1);
    chk("pre_rst_rdb", 32'(rdb), 32'd7);
    reset = 1'b0;
    #1;
    chk("mid_rst_rda", 32'(rda), 32'd0);
    chk("mid_rst_rdb", 32'(rdb), 32'd0);
    chk("mid_rst_busy", 32'(bsa), 32'd0);
    reset = 1'b1;
    we = 1; wd = 16'h7777; rb = 3'd3;
    step();
    we = 0; ra = 3'd4;
    chk("post_rst_err", 32'(err), 32'd1);
    chk("post_rst_reg1", 32'(rda), 32'd1);
    chk("post_rst_reg3", 32'(rdb), 32'd3);
    step();
    chk("post_rst_reg4", 32'(rda), 32'd4);

    // WB_DELAY=1 instance: issue 15, write next cycle, bypass read
    iv1 = 1; dv1 = 1; da1 = 4'd15; ra1 = 4'd15; rb1 = 4'd15;
    step();
    iv1 = 0; dv1 = 0;
    #1 chk("u1_busy_noen", 32'(bsa1), 32'd1);
    we1 = 1; wd1 = 32'hDEADBEEF;
    #1 chk("u1_busy_en", 32'(bsa1), 32'd0);
    step();
    we1 = 0;
    chk("u1_bypass_a", rda1, 32'hDEADBEEF);
    chk("u1_bypass_b", rdb1, 32'hDEADBEEF);
    chk("u1_no_err", 32'(err1), 32'd0);
    step();
    chk("u1_reg15", rda1, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/pipe_reg_file.md
Name: pipe_reg_file

Overview:
- Parametrised successor of the processor's 8x16 register file: configurable data width, register count and write-back latency, posedge-only timing.
- Owns the destination-address delay line: the write address is captured at issue and retired automatically D cycles later.
- Adds a write-to-read bypass, per-port busy (scoreboard) flags, pipeline flush and a write-back error flag.
- Sits between decode (issue side) and write-back (retire side).

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; power of two, minimum 2.
- ADDR_W, $clog2(NUM_REGS), register address width.
- WB_DELAY, 3, cycles from issue to write-back; minimum 1.
- INIT_MODE, 1, reset contents: 0 = all zero, 1 = register i holds value i.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  an instruction is issued this cycle.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- dest_valid  in  1  the issued instruction will write a register.
- dest_addr  in  ADDR_W  destination register of the issued instruction.
- flush  in  1  squash all in-flight destinations.
- wb_en  in  1  write-back strobe for the oldest in-flight destination.
- wb_data  in  DATA_W  write-back data.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_data_b  out  DATA_W  registered read data, port B.
- busy_a  out  1  combinational: a pending write targets rd_addr_a.
- busy_b  out  1  combinational: a pending write targets rd_addr_b.
- wb_err  out  1  registered one-cycle pulse: wb_en arrived with no valid pending destination.

Behaviour:
- Reset (reset=0, asynchronous):
  - registers loaded per INIT_MODE;
  - all delay stages invalid;
  - rd_data_a, rd_data_b and wb_err = 0.
  - Reset asserted mid-operation discards every in-flight write; no write happens on that edge.
- Delay line:
  - WB_DELAY stages, each {valid, addr}; stage[0] is youngest, stage[D-1] is the tail.
  - Each posedge: stage[0] <= {issue_valid & dest_valid & ~flush, dest_addr}; stage[i] <= stage[i-1].
- Write:
  - wb_fire = wb_en & stage[D-1].valid.
  - On posedge with wb_fire, regs[stage[D-1].addr] <= wb_data.
  - Net effect: an instruction issued in cycle t retires with wb_data presented in cycle t+D.
- Write-back error:
  - wb_en with an invalid tail: no register write; wb_err = 1 for the next cycle only.
  - Tail valid with wb_en=0: the write is dropped silently, and the entry leaves the line on that edge.
- Read:
  - One-cycle latency: rd_data_x <= (wb_fire & stage[D-1].addr == rd_addr_x) ? wb_data : regs[rd_addr_x].
  - Both ports may read the same address in one cycle; both get identical data.
  - Reads are sampled every cycle regardless of issue_valid.
- Busy:
  - busy_x = any stage[0..D-2] valid with addr == rd_addr_x, OR (stage[D-1] valid, addr == rd_addr_x, and wb_en = 0).
  - A tail entry being retired this cycle is covered by the bypass, so it does not assert busy.
  - The destination being issued in the current cycle never affects its own busy flags.
- Flush:
  - On the flush edge, every stage loads invalid and the issue slot is dropped.
  - A wb_fire on that same edge still completes, since the tail is retiring.
- Duplicates: several in-flight entries with the same addr are legal; each retires in order, and the last write wins.
- WB_DELAY = 1: the tail is stage[0]; busy reduces to (stage[0] match & ~wb_en).

Test Plan:
- Reset with INIT_MODE=1, then read a=5, b=7 -> one cycle later rd_data_a=5, rd_data_b=7; busy_a=busy_b=0; wb_err=0.
- Issue dest=3 in cycle 0; wb_en=1, wb_data=0xBEEF in cycle 3; read a=3 in cycles 1–4:
  - busy_a=1 in cycles 1–2;
  - busy_a=0 in cycle 3, and rd_data_a=0xBEEF after that edge (bypass);
  - regs[3]=0xBEEF from cycle 4 on.
- Issue dest=2 in cycle 0, flush in cycle 1, wb_en in cycle 3 -> busy clears from cycle 2; no write occurs (register 2 still 2); wb_err=1 in cycle 4.
- Issue dest=4 twice (cycles 0 and 1) with wb_data 0x0011 then 0x0022 -> register 4 reads 0x0022; busy_a for a=4 stays high through cycle 3.
- Assert reset asynchronously mid-cycle while 3 entries are pending -> outputs go to 0 immediately; busy deasserts; subsequent wb_en produces wb_err; registers back at INIT values.
- Parameter sweep DATA_W=32, NUM_REGS=16, WB_DELAY=1:
  - issue dest=15, wb_data=0xDEADBEEF next cycle -> write completes;
  - a read of 15 in the same cycle returns 0xDEADBEEF via bypass.
